// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive path
package uart_rx_pkg;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversample edge counter and frame bit counter
module uart_rx_edge_bit_counter #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [PRESCALE_WIDTH-1:0] edge_count,
    output logic [BIT_CNT_WIDTH-1:0]  bit_count,
    output logic                      bit_done
);

    logic last_edge;

    // >= rather than == so a counter can never run past the wrap point
    assign last_edge = (edge_count >= (prescale - PRESCALE_WIDTH'(1)));
    assign bit_done  = enable && last_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (clear) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (enable) begin
            if (last_edge) begin
                edge_count <= '0;
                bit_count  <= bit_count + BIT_CNT_WIDTH'(1);
            end else begin
                edge_count <= edge_count + PRESCALE_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame controller: start detect, deserialize, check
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      sampled_bit,
    output logic                      data_sample_en,
    output logic [PRESCALE_WIDTH-1:0] edge_count,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      strt_glitch,
    output logic                      busy
);

    localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 3);

    rx_state_t                 state, state_next;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q, par_typ_q;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      frame_bad;
    logic [BIT_CNT_WIDTH-1:0]  bit_count;
    logic                      bit_done;
    logic                      cnt_clear;
    logic                      latch_cfg, shift_en, parity_exp;
    logic                      data_valid_d, par_err_d, stp_err_d, strt_glitch_d;

    assign busy           = (state != IDLE);
    assign data_sample_en = busy;
    assign parity_exp     = par_typ_q ^ (^shift_reg);

    uart_rx_edge_bit_counter #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH),
        .BIT_CNT_WIDTH (BIT_CNT_WIDTH)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .enable    (busy),
        .clear     (cnt_clear),
        .prescale  (prescale_q),
        .edge_count(edge_count),
        .bit_count (bit_count),
        .bit_done  (bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        latch_cfg     = 1'b0;
        shift_en      = 1'b0;
        cnt_clear     = 1'b0;
        data_valid_d  = 1'b0;
        par_err_d     = 1'b0;
        stp_err_d     = 1'b0;
        strt_glitch_d = 1'b0;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (!RX_IN) begin
                    state_next = START;
                    latch_cfg  = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    strt_glitch_d = sampled_bit;
                    state_next    = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_en = 1'b1;
                    if (bit_count == BIT_CNT_WIDTH'(DATA_WIDTH))
                        state_next = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    par_err_d  = (sampled_bit != parity_exp);
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    stp_err_d    = !sampled_bit;
                    data_valid_d = sampled_bit && !frame_bad;
                    // a low line on the decision cycle is the next start bit
                    if (!RX_IN) begin
                        state_next = START;
                        latch_cfg  = 1'b1;
                        cnt_clear  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q  <= PRESCALE_WIDTH'(PRESCALE_8);
            par_en_q    <= 1'b0;
            par_typ_q   <= PAR_EVEN;
            shift_reg   <= '0;
            frame_bad   <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            data_valid  <= data_valid_d;
            par_err     <= par_err_d;
            stp_err     <= stp_err_d;
            strt_glitch <= strt_glitch_d;
            if (latch_cfg) begin
                prescale_q <= prescale;
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
            end
            if (shift_en)
                shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            if (par_err_d)
                frame_bad <= 1'b1;
            else if (state == STOP && bit_done)
                frame_bad <= 1'b0;
            if (data_valid_d)
                P_DATA <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       data_sample_en;
    logic [5:0] edge_count;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err, strt_glitch, busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_ctrl #(.PRESCALE_WIDTH(6), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .RX_IN         (RX_IN),
        .prescale      (prescale),
        .PAR_EN        (PAR_EN),
        .PAR_TYP       (PAR_TYP),
        .sampled_bit   (sampled_bit),
        .data_sample_en(data_sample_en),
        .edge_count    (edge_count),
        .P_DATA        (P_DATA),
        .data_valid    (data_valid),
        .par_err       (par_err),
        .stp_err       (stp_err),
        .strt_glitch   (strt_glitch),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // 3-tap majority sampler as built by the enclosing receiver
    logic       tap0 = 1'b1, tap1 = 1'b1, tap2 = 1'b1;
    logic [5:0] half;
    assign half        = prescale >> 1;
    assign sampled_bit = (tap0 & tap1) | (tap0 & tap2) | (tap1 & tap2);

    always @(posedge clk) begin
        if (data_sample_en) begin
            if (edge_count == half - 6'd1) tap0 <= RX_IN;
            if (edge_count == half)        tap1 <= RX_IN;
            if (edge_count == half + 6'd1) tap2 <= RX_IN;
        end
    end

    int   cyc = 0;
    int   dv_cnt = 0, pe_cnt = 0, se_cnt = 0, sg_cnt = 0, idle_cnt = 0;
    int   start_cyc = 0, dv_cyc = 0, prev_dv_cyc = 0, sg_cyc = 0;
    int   dv_idle = 0, prev_dv_idle = 0;
    logic busy_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        busy_q <= busy;
        if (busy && !busy_q) start_cyc <= cyc;
        if (!busy) idle_cnt <= idle_cnt + 1;
        if (data_valid) begin
            dv_cnt       <= dv_cnt + 1;
            prev_dv_cyc  <= dv_cyc;
            dv_cyc       <= cyc;
            prev_dv_idle <= dv_idle;
            dv_idle      <= idle_cnt;
        end
        if (par_err) pe_cnt <= pe_cnt + 1;
        if (stp_err) se_cnt <= se_cnt + 1;
        if (strt_glitch) begin
            sg_cnt <= sg_cnt + 1;
            sg_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int ps);
        RX_IN = b;
        repeat (ps) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit,
                              input logic stop_bit, input int ps);
        drive_bit(1'b0, ps);
        for (int i = 0; i < 8; i++) drive_bit(d[i], ps);
        if (with_par) drive_bit(par_bit, ps);
        drive_bit(stop_bit, ps);
    endtask

    task automatic idle_wait(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int dv0, pe0, se0, sg0;

    task automatic snap();
        #0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; sg0 = sg_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; RX_IN = 1'b1; prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sample_en", data_sample_en, 0);
        check_eq("rst_edge_count", edge_count, 0);
        check_eq("rst_p_data", P_DATA, 0);
        check_eq("rst_pulses", {data_valid, par_err, stp_err, strt_glitch}, 0);
        rst = 1'b0;
        idle_wait(2);

        // prescale 8, no parity, 0xA5
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
        idle_wait(6);
        check_eq("p8_pdata", P_DATA, 8'hA5);
        check_eq("p8_dv_count", dv_cnt - dv0, 1);
        check_eq("p8_latency", dv_cyc - start_cyc, 80);
        check_eq("p8_errors", (pe_cnt - pe0) + (se_cnt - se0) + (sg_cnt - sg0), 0);
        check_eq("p8_idle_busy", busy, 0);

        // prescale 16, even parity, 0x3C with correct then wrong parity
        prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
        idle_wait(6);
        check_eq("even_good_pdata", P_DATA, 8'h3C);
        check_eq("even_good_dv", dv_cnt - dv0, 1);
        check_eq("even_good_perr", pe_cnt - pe0, 0);
        check_eq("even_good_latency", dv_cyc - start_cyc, 176);
        snap();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
        idle_wait(6);
        check_eq("even_bad_perr", pe_cnt - pe0, 1);
        check_eq("even_bad_dv", dv_cnt - dv0, 0);
        check_eq("even_bad_pdata", P_DATA, 8'h3C);
        check_eq("even_bad_serr", se_cnt - se0, 0);

        // false start: line low for 3 cycles at prescale 8
        prescale = 6'd8; PAR_EN = 1'b0;
        snap();
        RX_IN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle_wait(12);
        check_eq("glitch_count", sg_cnt - sg0, 1);
        check_eq("glitch_cycle", sg_cyc - start_cyc, 8);
        check_eq("glitch_busy", busy, 0);
        check_eq("glitch_dv", dv_cnt - dv0, 0);

        // prescale 32, odd parity, stop bit low
        prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        snap();
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 32);
        idle_wait(6);
        check_eq("stop_serr", se_cnt - se0, 1);
        check_eq("stop_dv", dv_cnt - dv0, 0);
        check_eq("stop_perr", pe_cnt - pe0, 0);
        check_eq("stop_pdata", P_DATA, 8'h3C);
        check_eq("stop_busy", busy, 0);

        // back-to-back frames at prescale 8
        prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        snap();
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 8);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 8);
        idle_wait(6);
        check_eq("b2b_dv", dv_cnt - dv0, 2);
        check_eq("b2b_spacing", dv_cyc - prev_dv_cyc, 80);
        check_eq("b2b_no_idle", dv_idle - prev_dv_idle, 0);
        check_eq("b2b_pdata", P_DATA, 8'hFE);

        // reset during data bit 4, then a clean frame
        prescale = 6'd16;
        snap();
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
        RX_IN = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_sample_en", data_sample_en, 0);
        check_eq("mid_rst_edge", edge_count, 0);
        check_eq("mid_rst_pdata", P_DATA, 0);
        check_eq("mid_rst_pulses", {data_valid, par_err, stp_err, strt_glitch}, 0);
        idle_wait(3);
        rst = 1'b0;
        idle_wait(3);
        send_frame(8'h69, 1'b0, 1'b0, 1'b1, 16);
        idle_wait(6);
        check_eq("recover_pdata", P_DATA, 8'h69);
        check_eq("recover_dv", dv_cnt - dv0, 1);
        check_eq("recover_errors", (pe_cnt - pe0) + (se_cnt - se0) + (sg_cnt - sg0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
